// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON key schedule.
//   Z_SEQ      : the five 62-bit z constant sequences. Bit j of a sequence
//                (counting from its first published element) is Z_SEQ[s][61-j].
//   word_t     : default 16-bit word type.
//   ks_state_t : key-schedule FSM encoding.
//   simon_ror  : rotate-right of an n-bit word carried in a 64-bit container.
package simon_pkg;

  localparam int unsigned SIMON_N = 16;

  typedef logic [SIMON_N-1:0] word_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

  localparam logic [61:0] Z_SEQ [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  // Rotate the low n bits of w right by amt; bits above n are returned as 0.
  function automatic logic [63:0] simon_ror(input logic [63:0] w,
                                            input int unsigned amt,
                                            input int unsigned n);
    logic [63:0] mask;
    logic [63:0] wm;
    mask = (n >= 64) ? '1 : ((64'h1 << n) - 64'h1);
    wm   = w & mask;
    return ((wm >> amt) | (wm << (n - amt))) & mask;
  endfunction

endpackage

// File: rtl/simon_ks_round.sv
// One step of the SIMON key schedule, purely combinational.
//   k_im1 : k[i-1]        k_im3 : k[i-3] (only used when M == 4)
//   k_imm : k[i-M]        zbit  : z-sequence bit for this step
//   k_i   : k[i] = ~k[i-M] ^ tmp ^ zbit ^ 3
module simon_ks_round
  import simon_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4
) (
  input  logic [N-1:0] k_im1,
  input  logic [N-1:0] k_im3,
  input  logic [N-1:0] k_imm,
  input  logic         zbit,
  output logic [N-1:0] k_i
);

  logic [N-1:0] tmp;

  always_comb begin
    tmp = N'(simon_ror(64'(k_im1), 3, N));
    if (M == 4) begin
      tmp = tmp ^ k_im3;
    end
    tmp = tmp ^ N'(simon_ror(64'(tmp), 1, N));
    // ~x ^ 3 is the schedule constant 2^N-4 folded in with k[i-M].
    k_i = ~k_imm ^ tmp ^ {{(N-1){1'b0}}, zbit} ^ N'(3);
  end

endmodule

// File: rtl/simon_key_expand.sv
// SIMON key expansion: captures an M-word master key on newKEY, then
// generates one round key per clock into a T-entry store, and serves
// the store through a registered read port.
//   clk       : rising-edge clock
//   nR        : asynchronous active-low reset
//   newKEY    : load KEY and (re)start expansion on this edge
//   KEY       : master key, KEY[0] = k0
//   rkADDR    : round-key read index
//   rkOUT     : registered store[rkADDR], 0 when rkADDR >= T
//   keyBUSY   : expansion in progress
//   keyREADY  : all T round keys valid, held until the next newKEY
//   state_dbg : current FSM state
// Handshake: newKEY is a one-cycle strobe with no back-pressure; it is
// accepted on every edge it is high, aborting any running expansion.
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned M    = 4,
  parameter int unsigned T    = 32,
  parameter int unsigned ZSEL = 0
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newKEY,
  input  logic [M-1:0][N-1:0] KEY,
  input  logic [7:0]          rkADDR,
  output logic [N-1:0]        rkOUT,
  output logic                keyBUSY,
  output logic                keyREADY,
  output ks_state_t           state_dbg
);

  if (M < 2 || M > 4) begin : g_bad_m
    $error("simon_key_expand: M must be in 2..4");
  end
  if (T <= M || T > 255) begin : g_bad_t
    $error("simon_key_expand: T must satisfy M < T <= 255");
  end
  if (ZSEL > 4 || N > 64 || N < 4) begin : g_bad_zn
    $error("simon_key_expand: ZSEL must be 0..4 and N 4..64");
  end

  localparam int unsigned AW = $clog2(T);
  localparam int unsigned MW = $clog2(M);
  localparam logic [61:0] Z_VEC = Z_SEQ[ZSEL];

  ks_state_t    state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  // (i-M) mod 62 tracked directly so no divider is needed.
  logic [5:0]   zidx_q, zidx_d;
  logic [N-1:0] store_q [T];
  logic [N-1:0] store_d [T];
  logic [N-1:0] rk_out_q, rk_out_d;

  logic [N-1:0] k_im1, k_im3, k_imm, k_new;
  logic         zbit;

  // Operand fetch for the round function. Only meaningful once i >= M,
  // which always holds while expanding; otherwise operands are parked at 0.
  always_comb begin
    k_im1 = '0;
    k_im3 = '0;
    k_imm = '0;
    if (i_q >= AW'(M)) begin
      k_im1 = store_q[i_q - AW'(1)];
      if (M == 4) begin
        k_im3 = store_q[i_q - AW'(3)];
      end
      k_imm = store_q[i_q - AW'(M)];
    end
    zbit = Z_VEC[6'd61 - zidx_q];
  end

  simon_ks_round #(
    .N(N),
    .M(M)
  ) u_round (
    .k_im1 (k_im1),
    .k_im3 (k_im3),
    .k_imm (k_imm),
    .zbit  (zbit),
    .k_i   (k_new)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    zidx_d  = zidx_q;
    store_d = store_q;
    if (newKEY) begin
      // Load wins over everything: restart from the new key this edge.
      for (int j = 0; j < M; j++) begin
        store_d[AW'(j)] = KEY[MW'(j)];
      end
      i_d     = AW'(M);
      zidx_d  = '0;
      state_d = KS_EXPAND;
    end else if (state_q == KS_EXPAND) begin
      store_d[i_q] = k_new;
      i_d          = i_q + AW'(1);
      zidx_d       = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
      if (i_q == AW'(T - 1)) begin
        state_d = KS_DONE;
      end
    end
  end

  always_comb begin
    rk_out_d = '0;
    if ({24'b0, rkADDR} < T) begin
      rk_out_d = store_q[AW'(rkADDR)];
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q  <= KS_IDLE;
      i_q      <= '0;
      zidx_q   <= '0;
      store_q  <= '{default: '0};
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      zidx_q   <= zidx_d;
      store_q  <= store_d;
      rk_out_q <= rk_out_d;
    end
  end

  assign rkOUT     = rk_out_q;
  assign keyBUSY   = (state_q == KS_EXPAND);
  assign keyREADY  = (state_q == KS_DONE);
  assign state_dbg = state_q;

endmodule
